// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment display paths: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the all-anodes-off value.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'hF;

  // Pick BCD digit i (0 = rightmost) out of a packed 4-digit word.
  function automatic logic [3:0] digit_sel(input logic [15:0] word, input logic [1:0] i);
    return word[4*i +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display driver bus: digit/control inputs from the BCD stage and the
// multiplexed anode/segment outputs toward the display.
interface seg_scan_driver_if;

  logic       en;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic       load;
  logic       lz_en;
  logic [3:0] blink_mask;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output en, bcd0, bcd1, bcd2, bcd3, load, lz_en, blink_mask, dp_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  en, bcd0, bcd1, bcd2, bcd3, load, lz_en, blink_mask, dp_mask,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD code to active-low 7-segment pattern; illegal codes show '-'.
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup; codes 10-15 fall through to the dash pattern.
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with tear-free
// frame-boundary digit updates, leading-zero blanking, blink and dead time.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1_000,
  parameter int unsigned DEAD_CYC  = 8,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_driver_if.slave    bus
);

  localparam int unsigned SLOT = CLK_HZ / SCAN_HZ;
  localparam int unsigned SW   = $clog2(SLOT);
  localparam int unsigned BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [15:0]   pending;
  logic [15:0]   shown;
  logic          pend_valid;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          upper_zero;
  logic          blank;

  assign slot_end  = (slot_cnt == SW'(SLOT - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign cur_digit = digit_sel(shown, idx);

  seg7_decode u_dec (
    .code (cur_digit),
    .seg  (dec_seg)
  );

  // Slot counter, digit index and blink divider; all advance on slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= idx + 2'd1;
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Pending/shown digits: the frame boundary consumes the pending value held
  // before this edge, so a coincident load waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      shown      <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (frame_end && pend_valid) begin
        shown <= pending;
      end
      if (bus.load) begin
        pending    <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Leading-zero detect: current digit and every more significant one are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((i >= 32'(idx)) && (shown[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Blank conditions for the digit being scanned.
  always_comb begin
    blank = !bus.en
         || (slot_cnt < SW'(DEAD_CYC))
         || (bus.blink_mask[idx] && phase)
         || (bus.lz_en && (idx != 2'd0) && upper_zero);
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an         <= blank ? AN_OFF  : ~(4'b0001 << idx);
      bus.seg        <= blank ? SEG_OFF : dec_seg;
      bus.dp         <= blank | ~bus.dp_mask[idx];
      bus.frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a time-indexed reference model.
module tb_seg_scan_driver;

  localparam int SLOT  = 10;
  localparam int DEAD  = 2;
  localparam int BDIV  = 2;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_driver_if bus();

  seg_scan_driver #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .DEAD_CYC  (DEAD),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: n = clock edges since reset release.
  int          n;
  logic [15:0] shown_m;
  logic [15:0] pend_m;
  logic        pv_m;
  logic [11:0] exp_out;
  logic        exp_fd;
  logic [6:0]  seg_tab [16];

  task automatic model_reset();
    n = 0; shown_m = 16'h0000; pend_m = 16'h0000; pv_m = 1'b0;
  endtask

  // One clock edge: expectation from time position and inputs, then state update.
  task automatic tick();
    int sc, s, ix, ph;
    logic lzb, blank;
    logic [3:0] d;
    logic [3:0] an_e;
    @(posedge clk);
    sc = n % SLOT;
    s  = n / SLOT;
    ix = s % 4;
    ph = (s / BDIV) % 2;
    d  = shown_m[ix*4 +: 4];
    lzb   = bus.lz_en && (ix > 0) && ((shown_m >> (4*ix)) == 16'h0);
    blank = !bus.en || (sc < DEAD) || (bus.blink_mask[ix] && ph == 1) || lzb;
    an_e  = ~(4'b0001 << ix);
    exp_out = blank ? {4'hF, 7'h7F, 1'b1} : {an_e, seg_tab[d], ~bus.dp_mask[ix]};
    exp_fd  = (sc == SLOT - 1) && (ix == 3);
    if (exp_fd) begin
      if (pv_m) shown_m = pend_m;
      pv_m = 1'b0;
    end
    if (bus.load) begin
      pend_m = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
      pv_m = 1'b1;
    end
    n++;
    #1;
  endtask

  task automatic set_digits(input logic [15:0] v);
    {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} = v;
  endtask

  task automatic test_reset();
    int first_fd;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: got an=%h seg=%h dp=%b fd=%b, want an=f seg=7f dp=1 fd=0",
                 bus.an, bus.seg, bus.dp, bus.frame_done);
      end
    end
    rst_n = 1'b1;
    model_reset();
    first_fd = -1;
    for (int i = 1; i <= 2 * FRAME && first_fd < 0; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL reset_scan n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
      if (bus.frame_done === 1'b1) first_fd = i;
    end
    checks++;
    if (first_fd != FRAME) begin
      errors++;
      $display("FAIL first_frame_done: got clk %0d, want clk %0d", first_fd, FRAME);
    end
  endtask

  task automatic test_scan();
    bus.lz_en = 1'b0;
    set_digits(16'h0123);
    bus.load = 1'b1; tick(); bus.load = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL scan n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
      // Digit 0 mid-slot must show '3' once the load has been applied.
      if (n > 2 * FRAME && (n - 1) % FRAME == 5) begin
        checks++;
        if ({bus.an, bus.seg} !== {4'hE, 7'b0110000}) begin
          errors++;
          $display("FAIL scan_digit0: got an=%h seg=%b, want an=e seg=0110000", bus.an, bus.seg);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    vals[0] = 16'h0005; vals[1] = 16'h0000;
    bus.lz_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      set_digits(vals[v]);
      bus.load = 1'b1; tick(); bus.load = 1'b0;
      for (int i = 0; i < 2 * FRAME + 5; i++) begin
        tick();
        checks++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
          errors++;
          $display("FAIL lz v=%h n=%0d: got %h_%b, want %h_%b", vals[v], n,
                   {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
        end
      end
    end
  endtask

  task automatic test_last_load();
    // Two loads within one frame: the first must never reach the display.
    while (n % FRAME != 5) tick();
    set_digits(16'h1234); bus.load = 1'b1; tick(); bus.load = 1'b0;
    repeat (10) tick();
    set_digits(16'h5678); bus.load = 1'b1; tick(); bus.load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL last_load n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
    end
    // Load on the frame-end edge: applied one frame later.
    while (n % FRAME != FRAME - 1) tick();
    set_digits(16'h0987); bus.load = 1'b1; tick(); bus.load = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1 || shown_m !== 16'h5678) begin
      errors++;
      $display("FAIL coincident_load: got fd=%b, want fd=1 with old digits kept", bus.frame_done);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL coincident n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
    end
  endtask

  task automatic test_blink_dash_dp();
    bus.lz_en = 1'b0;
    bus.blink_mask = 4'b0001;
    bus.dp_mask = 4'b0100;
    set_digits(16'h409C);
    bus.load = 1'b1; tick(); bus.load = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL blink n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
      if (bus.dp === 1'b0 && bus.an !== 4'hB) begin
        checks++;
        errors++;
        $display("FAIL dp_digit: got dp=0 with an=%h, want an=b", bus.an);
      end
    end
    bus.blink_mask = 4'b0000;
    bus.dp_mask = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (i % 23 == 0) begin
        bus.lz_en      = 1'($urandom_range(0, 1));
        bus.blink_mask = 4'($urandom_range(0, 15));
        bus.dp_mask    = 4'($urandom_range(0, 15));
      end
      bus.en   = ($urandom_range(0, 7) != 0);
      bus.load = ($urandom_range(0, 11) == 0);
      set_digits(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom & 32'h0000_0F9F));
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL random n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
    end
    bus.load = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    set_digits(16'h0042); bus.load = 1'b1; tick(); bus.load = 1'b0;
    while (n % FRAME != 17) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: got an=%h seg=%h dp=%b, want an=f seg=7f dp=1",
               bus.an, bus.seg, bus.dp);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {exp_out, exp_fd}) begin
        errors++;
        $display("FAIL restart n=%0d: got %h_%b, want %h_%b", n,
                 {bus.an, bus.seg, bus.dp}, bus.frame_done, exp_out, exp_fd);
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    bus.en = 1'b1; bus.load = 1'b0; bus.lz_en = 1'b0;
    bus.blink_mask = 4'b0000; bus.dp_mask = 4'b0000;
    set_digits(16'h0000);
    model_reset();
    test_reset();
    test_scan();
    test_lz();
    test_last_load();
    test_blink_dash_dp();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
